// File: rtl/gpu_mem_pkg.sv
// Shared types for the core memory path: arbiter FSM states, LSU state codes, Q1.15 word.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gpu_mem_pkg;

  // Arbiter FSM: one memory transaction in flight at a time.
  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    READ_WAITING  = 2'd1,
    WRITE_WAITING = 2'd2,
    RELAY         = 2'd3
  } arb_state_t;

  // LSU-side state codes, shared with the LSU array so both ends agree.
  localparam logic [1:0] LSU_STATE_IDLE       = 2'd0;
  localparam logic [1:0] LSU_STATE_REQUESTING = 2'd1;
  localparam logic [1:0] LSU_STATE_WAITING    = 2'd2;
  localparam logic [1:0] LSU_STATE_DONE       = 2'd3;

  // Signed fixed-point data word: 1 sign/integer bit, 15 fraction bits.
  localparam int Q1_15_BITS = 16;
  typedef logic [Q1_15_BITS-1:0] q1_15_t;

endpackage

// File: rtl/lsu_mem_arbiter_rr_pick.sv
// Round-robin first-set search: lowest-offset requester at or after ptr_i (mod N) wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
//   req_i   : per-requester request bits
//   ptr_i   : index with highest priority this cycle
//   grant_o : winning index (0 when any_o=0)
//   any_o   : at least one request present
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_o
);

  int               idx;
  logic [IDX_W-1:0] sel;

  // Walk offsets from the farthest to the nearest so the nearest requester
  // overwrites the others; no early exit needed.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      sel = IDX_W'(idx);
      if (req_i[sel]) begin
        grant_o = sel;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Shares one data-memory port between NUM_CONSUMERS LSUs, round-robin, one transaction in flight.
// Latency: LSU valid at edge t -> mem valid at t+1; mem ready at edge u -> LSU ready at u+1.
// Backpressure: LSU ready is held until that LSU drops valid; memory is waited on indefinitely.
//   clk, reset_n               : clock, asynchronous active-low reset
//   consumer_read_*            : per-LSU read request (valid/address in, ready/data out)
//   consumer_write_*           : per-LSU write request (valid/address/data in, ready out)
//   mem_read_* / mem_write_*   : single memory port (valid/address/data out, ready/data in)
//   perf_reads / perf_writes   : saturating completion counters, present only with LSU_ARB_PERF_EN
module lsu_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data,
  output logic                                    mem_write_valid,
  output logic [ADDR_BITS-1:0]                    mem_write_address,
  output logic [DATA_BITS-1:0]                    mem_write_data,
  input  logic                                    mem_write_ready
`ifdef LSU_ARB_PERF_EN
  ,
  output logic [15:0]                             perf_reads,
  output logic [15:0]                             perf_writes
`endif
);

  localparam int IDX_W = $clog2(NUM_CONSUMERS);

  arb_state_t state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic             is_read_q, is_read_d;

  logic [NUM_CONSUMERS-1:0]                rd_rdy_q, rd_rdy_d;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rd_dat_q, rd_dat_d;
  logic [NUM_CONSUMERS-1:0]                wr_rdy_q, wr_rdy_d;
  logic                                    mem_rd_vld_q, mem_rd_vld_d;
  logic [ADDR_BITS-1:0]                    mem_rd_addr_q, mem_rd_addr_d;
  logic                                    mem_wr_vld_q, mem_wr_vld_d;
  logic [ADDR_BITS-1:0]                    mem_wr_addr_q, mem_wr_addr_d;
  logic [DATA_BITS-1:0]                    mem_wr_dat_q, mem_wr_dat_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             lane_vld;

  rr_pick #(
    .N     (NUM_CONSUMERS),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i   (consumer_read_valid | consumer_write_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    cur_d         = cur_q;
    is_read_d     = is_read_q;
    rd_rdy_d      = rd_rdy_q;
    rd_dat_d      = rd_dat_q;
    wr_rdy_d      = wr_rdy_q;
    mem_rd_vld_d  = mem_rd_vld_q;
    mem_rd_addr_d = mem_rd_addr_q;
    mem_wr_vld_d  = mem_wr_vld_q;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_dat_d  = mem_wr_dat_q;
    lane_vld      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          cur_d = pick_idx;
          // A lane asserting both read and write is served its read first.
          if (consumer_read_valid[pick_idx]) begin
            is_read_d     = 1'b1;
            mem_rd_vld_d  = 1'b1;
            mem_rd_addr_d = consumer_read_address[pick_idx];
            state_d       = READ_WAITING;
          end else begin
            is_read_d     = 1'b0;
            mem_wr_vld_d  = 1'b1;
            mem_wr_addr_d = consumer_write_address[pick_idx];
            mem_wr_dat_d  = consumer_write_data[pick_idx];
            state_d       = WRITE_WAITING;
          end
        end
      end

      READ_WAITING: begin
        if (mem_read_ready) begin
          mem_rd_vld_d    = 1'b0;
          rd_rdy_d[cur_q] = 1'b1;
          rd_dat_d[cur_q] = mem_read_data;
          state_d         = RELAY;
        end
      end

      WRITE_WAITING: begin
        if (mem_write_ready) begin
          mem_wr_vld_d    = 1'b0;
          wr_rdy_d[cur_q] = 1'b1;
          state_d         = RELAY;
        end
      end

      RELAY: begin
        // Release only once the owning LSU has seen ready and withdrawn its
        // request; an LSU that already gave up gets a one-cycle pulse.
        lane_vld = is_read_q ? consumer_read_valid[cur_q] : consumer_write_valid[cur_q];
        if (!lane_vld) begin
          rd_rdy_d = '0;
          wr_rdy_d = '0;
          // Priority moves past the lane just served.
          rr_ptr_d = (cur_q == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : cur_q + IDX_W'(1);
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      cur_q         <= '0;
      is_read_q     <= 1'b0;
      rd_rdy_q      <= '0;
      rd_dat_q      <= '0;
      wr_rdy_q      <= '0;
      mem_rd_vld_q  <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_wr_vld_q  <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_dat_q  <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_q         <= cur_d;
      is_read_q     <= is_read_d;
      rd_rdy_q      <= rd_rdy_d;
      rd_dat_q      <= rd_dat_d;
      wr_rdy_q      <= wr_rdy_d;
      mem_rd_vld_q  <= mem_rd_vld_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      mem_wr_vld_q  <= mem_wr_vld_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_dat_q  <= mem_wr_dat_d;
    end
  end

  assign consumer_read_ready  = rd_rdy_q;
  assign consumer_read_data   = rd_dat_q;
  assign consumer_write_ready = wr_rdy_q;
  assign mem_read_valid       = mem_rd_vld_q;
  assign mem_read_address     = mem_rd_addr_q;
  assign mem_write_valid      = mem_wr_vld_q;
  assign mem_write_address    = mem_wr_addr_q;
  assign mem_write_data       = mem_wr_dat_q;

`ifdef LSU_ARB_PERF_EN
  logic [15:0] perf_rd_q;
  logic [15:0] perf_wr_q;
  logic        rd_done;
  logic        wr_done;

  // A completion is the WAITING -> RELAY transition.
  assign rd_done = (state_q == READ_WAITING) && mem_read_ready;
  assign wr_done = (state_q == WRITE_WAITING) && mem_write_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_rd_q <= '0;
      perf_wr_q <= '0;
    end else begin
      if (rd_done && (perf_rd_q != 16'hFFFF)) perf_rd_q <= perf_rd_q + 16'd1;
      if (wr_done && (perf_wr_q != 16'hFFFF)) perf_wr_q <= perf_wr_q + 16'd1;
    end
  end

  assign perf_reads  = perf_rd_q;
  assign perf_writes = perf_wr_q;
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: directed scenarios plus randomized LSU traffic.
// Expected grants come from a first-pending-after-last-served model; completions from a scoreboard queue.
// A memory responder with random latency closes the loop.
module tb_lsu_mem_arbiter;
  import gpu_mem_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N-1:0]         crv, crr, cwv, cwr;
  logic [N-1:0][AW-1:0] cra, cwa;
  logic [N-1:0][DW-1:0] crd, cwd;
  logic                 mrv, mwv;
  logic                 mrr = 1'b0;
  logic                 mwr = 1'b0;
  logic [AW-1:0]        mra, mwa;
  logic [DW-1:0]        mwd;
  q1_15_t               mrd = '0;

  // Per-lane request registers, each written only by its own lane process.
  logic         lrv[N];
  logic         lwv[N];
  logic [AW-1:0] lra[N];
  logic [AW-1:0] lwa[N];
  logic [DW-1:0] lwd[N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      crv[i] = lrv[i];
      cwv[i] = lwv[i];
      cra[i] = lra[i];
      cwa[i] = lwa[i];
      cwd[i] = lwd[i];
    end
  end

`ifdef LSU_ARB_PERF_EN
  logic [15:0] perf_reads, perf_writes;
`endif

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .consumer_read_valid    (crv),
    .consumer_read_address  (cra),
    .consumer_read_ready    (crr),
    .consumer_read_data     (crd),
    .consumer_write_valid   (cwv),
    .consumer_write_address (cwa),
    .consumer_write_data    (cwd),
    .consumer_write_ready   (cwr),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr)
`ifdef LSU_ARB_PERF_EN
    ,
    .perf_reads             (perf_reads),
    .perf_writes            (perf_writes)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- reference model / scoreboard state ----------------
  typedef struct {
    int          lane;
    bit          rd;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t          exp_q[$];
  int            grant_log[$];     // lane*2 + (1 for read, 0 for write)
  int            cyc = 0;
  int            mptr = 0;         // model priority: lane after the last one served
  logic [DW-1:0] dm[N];            // model of each lane's read-data register
  int            n_rd = 0, n_wr = 0;
  logic [N-1:0]  prev_crr = '0, prev_cwr = '0;
  logic          prev_mrv = 1'b0, prev_mwv = 1'b0;
  logic          snap_rv[N], snap_wv[N];
  logic [AW-1:0] snap_ra[N], snap_wa[N];
  logic [DW-1:0] snap_wd[N];
  int            cur_lane = 0;
  bit            cur_rd = 1'b0;
  int            rstate = 0, dly = 0;
  bit            resp_en = 1'b1;
  int            force_delay = -1;
  bit            force_data_en = 1'b0;
  logic [DW-1:0] force_data = '0;

  task automatic clear_model();
    exp_q.delete();
    grant_log.delete();
    mptr = 0; n_rd = 0; n_wr = 0; rstate = 0;
    mrr = 1'b0; mwr = 1'b0;
    prev_crr = '0; prev_cwr = '0; prev_mrv = 1'b0; prev_mwv = 1'b0;
    for (int i = 0; i < N; i++) begin
      dm[i] = '0; snap_rv[i] = 1'b0; snap_wv[i] = 1'b0;
      snap_ra[i] = '0; snap_wa[i] = '0; snap_wd[i] = '0;
    end
  endtask

  // Monitor + memory responder, one negedge process so ordering is fixed.
  initial begin
    logic [N-1:0] rise_r, rise_w;
    int           got_l, gl;
    bit           found, new_grant;
    exp_t         e;
    clear_model();
    forever begin
      @(negedge clk);
      cyc++;
      new_grant = 1'b0;
      if (reset_n !== 1'b1) begin
        clear_model();
        continue;
      end
      // Completion: a consumer ready has just risen.
      rise_r = crr & ~prev_crr;
      rise_w = cwr & ~prev_cwr;
      if ((rise_r | rise_w) != '0) begin
        chk("one_completion", $countones(rise_r | rise_w), 1);
        got_l = 0;
        for (int l = 0; l < N; l++) if (rise_r[l] | rise_w[l]) got_l = l;
        if (exp_q.size() == 0) begin
          chk("unexpected_ready", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_lane", got_l, e.lane);
          chk("done_op", rise_r != '0, e.rd);
          chk("done_latency", cyc, e.due);
          if (e.rd) begin dm[e.lane] = e.data; n_rd++; end
          else n_wr++;
          for (int l = 0; l < N; l++) chk("read_data_lane", crd[l], dm[l]);
          chk("mem_valid_dropped", mrv | mwv, 0);
        end
      end
      prev_crr = crr;
      prev_cwr = cwr;
      chk("one_mem_valid", mrv & mwv, 0);
      // New grant: rising memory valid; decided on the inputs of the previous snapshot.
      if ((mrv && !prev_mrv) || (mwv && !prev_mwv)) begin
        found = 1'b0; gl = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && (snap_rv[(mptr + k) % N] || snap_wv[(mptr + k) % N])) begin
            found = 1'b1;
            gl = (mptr + k) % N;
          end
        end
        chk("grant_has_requester", found, 1);
        if (found) begin
          chk("grant_op_read", mrv, snap_rv[gl]);
          if (snap_rv[gl]) chk("grant_rd_addr", mra, snap_ra[gl]);
          else begin
            chk("grant_wr_addr", mwa, snap_wa[gl]);
            chk("grant_wr_data", mwd, snap_wd[gl]);
          end
          grant_log.push_back(gl * 2 + int'(snap_rv[gl]));
          mptr      = (gl + 1) % N;
          cur_lane  = gl;
          cur_rd    = snap_rv[gl];
          new_grant = 1'b1;
        end
      end
      prev_mrv = mrv;
      prev_mwv = mwv;
      for (int l = 0; l < N; l++) begin
        snap_rv[l] = lrv[l]; snap_wv[l] = lwv[l];
        snap_ra[l] = lra[l]; snap_wa[l] = lwa[l]; snap_wd[l] = lwd[l];
      end
      // Memory responder: one-cycle ready pulse after a random delay.
      if (rstate == 2) begin
        mrr = 1'b0; mwr = 1'b0; rstate = 0;
      end
      if (rstate == 0 && new_grant && resp_en) begin
        dly = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
        rstate = 1;
      end
      if (rstate == 1) begin
        if (dly == 0) begin
          if (cur_rd) begin
            mrd = force_data_en ? force_data : DW'($urandom);
            mrr = 1'b1;
          end else mwr = 1'b1;
          exp_q.push_back('{lane: cur_lane, rd: cur_rd, data: mrd, due: cyc + 1});
          rstate = 2;
        end else dly--;
      end
    end
  end

  // ---------------- LSU drivers ----------------
  task automatic wait_ready(input int l, input bit rd);
    bit got = 1'b0;
    int n = 0;
    while (n < 400 && !got) begin
      @(negedge clk);
      got = rd ? crr[l] : cwr[l];
      n++;
    end
    chk("ready_within_budget", got, 1);
    @(posedge clk); #1;
    if (rd) lrv[l] = 1'b0; else lwv[l] = 1'b0;
    if (got) begin
      @(negedge clk);
      chk("ready_held_2nd_cycle", rd ? crr[l] : cwr[l], 1);
      @(posedge clk); @(negedge clk);
      chk("ready_cleared", rd ? crr[l] : cwr[l], 0);
    end
  endtask

  // op: 0 read, 1 write, 2 read and write together
  task automatic lane_txn(input int l, input int op, input logic [AW-1:0] a_r,
                          input logic [AW-1:0] a_w, input logic [DW-1:0] d_w);
    @(posedge clk); #1;
    if (op != 1) begin lrv[l] = 1'b1; lra[l] = a_r; end
    if (op != 0) begin lwv[l] = 1'b1; lwa[l] = a_w; lwd[l] = d_w; end
    if (op != 1) wait_ready(l, 1'b1);
    if (op != 0) wait_ready(l, 1'b0);
  endtask

  task automatic lane_random(input int l, input int n);
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      lane_txn(l, int'($urandom_range(0, 2)), AW'($urandom), AW'($urandom), DW'($urandom));
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, {|crr, |cwr, |crd, mrv, mwv, |mra, |mwa, |mwd}, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    for (int i = 0; i < N; i++) begin
      lrv[i] = 1'b0; lwv[i] = 1'b0; lra[i] = '0; lwa[i] = '0; lwd[i] = '0;
    end
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 chk_outputs_zero("reset_state");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // Reset while a read is waiting on memory.
    resp_en = 1'b0;
    @(posedge clk); #1 lrv[2] = 1'b1; lra[2] = 8'h33;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = mrv; end
    chk("rst_test_read_issued", seen, 1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_outputs_zero("reset_mid_waiting");
    lrv[2] = 1'b0;
    @(negedge clk); #2 reset_n = 1'b1; resp_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_after_release", {mrv, mwv, |crr, |cwr}, 0);
    end

    // Single read: LSU2 addr 0x10, memory answers 0x4000 after 3 cycles.
    force_delay = 3; force_data_en = 1'b1; force_data = 16'h4000;
    lane_txn(2, 0, 8'h10, 8'h00, 16'h0000);
    chk("single_read_data_held", crd[2], 16'h4000);
    force_delay = -1; force_data_en = 1'b0;

    // Round-robin from priority 0: all four read together, then lane 0 alone wraps.
    pulse_reset();
    fork
      lane_txn(0, 0, 8'h01, 8'h00, 16'h0);
      lane_txn(1, 0, 8'h02, 8'h00, 16'h0);
      lane_txn(2, 0, 8'h03, 8'h00, 16'h0);
      lane_txn(3, 0, 8'h04, 8'h00, 16'h0);
    join
    lane_txn(0, 0, 8'h05, 8'h00, 16'h0);
    chk("rr_log_len", grant_log.size(), 5);
    if (grant_log.size() >= 5)
      for (int i = 0; i < 5; i++) chk("rr_order", grant_log[i], (i % 4) * 2 + 1);

    // Mixed: LSU1 write and LSU3 read together; write goes first.
    pulse_reset();
    fork
      lane_txn(1, 1, 8'h00, 8'h20, 16'h8001);
      lane_txn(3, 0, 8'h30, 8'h00, 16'h0);
    join
    chk("mixed_log_len", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("mixed_first_write_lane1", grant_log[0], 2);
      chk("mixed_then_read_lane3", grant_log[1], 7);
    end

    // Same lane read+write: read served first, write on the next pass.
    pulse_reset();
    lane_txn(0, 2, 8'h40, 8'h41, 16'h1234);
    chk("same_lane_log_len", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("same_lane_read_first", grant_log[0], 1);
      chk("same_lane_write_next", grant_log[1], 0);
    end

    // Requester withdraws while memory is busy: still one ready pulse, no hang.
    force_delay = 3;
    @(posedge clk); #1 lrv[1] = 1'b1; lra[1] = 8'h55;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = mrv; end
    chk("drop_test_read_issued", seen, 1);
    @(posedge clk); #1 lrv[1] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = crr[1]; end
    chk("drop_test_ready_pulse", seen, 1);
    @(negedge clk);
    chk("drop_test_pulse_one_cycle", crr[1], 0);
    force_delay = -1;

    // Randomized traffic on all lanes.
    pulse_reset();
    fork
      lane_random(0, 25);
      lane_random(1, 25);
      lane_random(2, 25);
      lane_random(3, 25);
    join
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_idle", {mrv, mwv, |crr, |cwr}, 0);
`ifdef LSU_ARB_PERF_EN
    chk("perf_reads", perf_reads, n_rd);
    chk("perf_writes", perf_writes, n_wr);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
